// File: rtl/tdc_encoder_pkg.sv
// tdc_enc_pkg: shared constants and types for the TDC hit encoder.
//   FINE_STAGES / FINE_BINS : ring length and the number of fine phases per ring period
//   LOW_TH / HIGH_TH        : fine-phase window in which coarse counter A is trusted
//   fine_phase_t            : 7-bit fine phase, range 0..109
package tdc_enc_pkg;
  localparam int FINE_STAGES = 55;
  localparam int FINE_BINS   = 2 * FINE_STAGES;
  localparam int FINE_W      = FINE_STAGES;
  localparam int CNT_W       = 5;
  localparam int OUT_W       = 12;
  localparam int PC_W        = 6;
  localparam int PH_W        = 7;

  typedef logic [PH_W-1:0] fine_phase_t;

  localparam fine_phase_t LOW_TH  = 7'd28;
  localparam fine_phase_t HIGH_TH = 7'd82;
endpackage

// File: rtl/tdc_encoder_if.sv
// tdc_encoder_if: snapshot bus from the TDC front-end latches to the encoder.
//   fine_raw_code : 55-bit ring snapshot, bit 0 = first stage
//   counterA/B    : 5-bit coarse counters (A mid-window, B edge-window)
//   TDC_bin_code  : 12-bit encoded time returned by the encoder
//   master = front-end / driver side, slave = encoder side
interface tdc_encoder_if;
  import tdc_enc_pkg::*;

  logic [FINE_W-1:0] fine_raw_code;
  logic [CNT_W-1:0]  counterA;
  logic [CNT_W-1:0]  counterB;
  logic [OUT_W-1:0]  TDC_bin_code;

  modport master (output fine_raw_code, output counterA, output counterB,
                  input  TDC_bin_code);
  modport slave  (input  fine_raw_code, input  counterA, input  counterB,
                  output TDC_bin_code);
endinterface

// File: rtl/tdc_encoder_popcount55.sv
// tdc_popcount55: combinational population count of a 55-bit word.
//   bits  : input word
//   count : number of ones, 0..55
module tdc_popcount55
  import tdc_enc_pkg::*;
(
  input  logic [FINE_W-1:0] bits,
  output logic [PC_W-1:0]   count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < FINE_W; i++)
      count = count + PC_W'(bits[i]);
  end
endmodule

// File: rtl/tdc_encoder.sv
// tdc_encoder: turns one TDC hit snapshot into a 12-bit time code
//   code = coarse*110 + fine phase, registered on clk40M.
//   clk40M : system clock, rising edge
//   rst    : synchronous active-high reset, clears the output (and input stage)
//   bus    : tdc_encoder_if.slave (snapshot in, TDC_bin_code out)
// Build option: define TDC_ENC_INPUT_REG_EN to add an input register stage
// (latency 2 instead of 1).
module tdc_encoder
  import tdc_enc_pkg::*;
(
  input  logic          clk40M,
  input  logic          rst,
  tdc_encoder_if.slave  bus
);
  logic [FINE_W-1:0] fine_q;
  logic [CNT_W-1:0]  cnt_a_q;
  logic [CNT_W-1:0]  cnt_b_q;

`ifdef TDC_ENC_INPUT_REG_EN
  // Reset value 0 encodes to code 0, so the pipe shows 0 for two cycles.
  always_ff @(posedge clk40M) begin
    if (rst) begin
      fine_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      fine_q  <= bus.fine_raw_code;
      cnt_a_q <= bus.counterA;
      cnt_b_q <= bus.counterB;
    end
  end
`else
  assign fine_q  = bus.fine_raw_code;
  assign cnt_a_q = bus.counterA;
  assign cnt_b_q = bus.counterB;
`endif

  // Last stage tells which half-period the edge is in: first half counts
  // ones, second half counts the zeros left behind the falling front.
  // Counting instead of locating the edge absorbs thermometer bubbles.
  logic              second_half;
  logic [FINE_W-1:0] pc_in;
  logic [PC_W-1:0]   pc;
  fine_phase_t       fine_ph;

  assign second_half = fine_q[FINE_W-1];
  assign pc_in       = second_half ? ~fine_q : fine_q;

  tdc_popcount55 u_popcount (
    .bits  (pc_in),
    .count (pc)
  );

  assign fine_ph = second_half ? PH_W'(FINE_STAGES) + PH_W'(pc) : PH_W'(pc);

  // Counter A may be mid-toggle near the period edges; there use B, which
  // toggles half a period later. Late in the period B has already advanced,
  // so step it back (mod 32).
  logic [CNT_W-1:0] coarse;
  always_comb begin
    coarse = cnt_a_q;
    if (fine_ph < LOW_TH)
      coarse = cnt_b_q;
    else if (fine_ph > HIGH_TH)
      coarse = cnt_b_q - CNT_W'(1);
  end

  // Max 31*110+109 = 3519 fits in 12 bits.
  logic [OUT_W-1:0] code;
  assign code = OUT_W'(coarse) * OUT_W'(FINE_BINS) + OUT_W'(fine_ph);

  always_ff @(posedge clk40M) begin
    if (rst) bus.TDC_bin_code <= '0;
    else     bus.TDC_bin_code <= code;
  end
endmodule

// File: tb/tb_tdc_encoder.sv
module tb_tdc_encoder;
`ifdef TDC_ENC_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk40M = 1'b0;
  logic rst    = 1'b1;
  always #5 clk40M = ~clk40M;

  tdc_encoder_if bus ();

  tdc_encoder dut (
    .clk40M (clk40M),
    .rst    (rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level model: phase from popcount, coarse from the window rules.
  function automatic int model_enc(input logic [54:0] fr, input int a, input int b);
    int f, c;
    logic [54:0] inv;
    inv = ~fr;
    if (fr[54]) f = 55 + $countones(inv);
    else        f = $countones(fr);
    if (f < 28)      c = b;
    else if (f > 82) c = (b + 31) % 32;
    else             c = a;
    return c * 110 + f;
  endfunction

  function automatic logic [54:0] lo_ones(input int n);
    logic [54:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [54:0] hi_ones(input int n);
    return ~lo_ones(55 - n);
  endfunction

  // Model pipeline; stage0 only matters with the input register stage.
  int  stage0  = 0;
  int  exp_out = 0;
  bit  started = 0;

  always @(posedge clk40M) begin
    if (rst) begin
      stage0  <= 0;
      exp_out <= 0;
      started <= 1'b1;
    end else begin
      stage0  <= model_enc(bus.fine_raw_code, int'(bus.counterA), int'(bus.counterB));
      exp_out <= (LAT == 1) ? model_enc(bus.fine_raw_code, int'(bus.counterA), int'(bus.counterB))
                            : stage0;
    end
  end

  always @(negedge clk40M)
    if (started) check("cycle", int'(bus.TDC_bin_code), exp_out);

  task automatic vec(input logic [54:0] fr, input int a, input int b,
                     input int exp, input string nm);
    @(posedge clk40M); #2;
    bus.fine_raw_code = fr;
    bus.counterA      = 5'(a);
    bus.counterB      = 5'(b);
    repeat (LAT) @(posedge clk40M);
    #1;
    check(nm, int'(bus.TDC_bin_code), exp);
    check({nm, "_model"}, exp_out, exp);
  endtask

  initial begin
    bus.fine_raw_code = '0;
    bus.counterA      = '0;
    bus.counterB      = '0;
    rst = 1'b1;
    @(posedge clk40M); #1;
    check("reset", int'(bus.TDC_bin_code), 0);
    @(posedge clk40M); #2;
    rst = 1'b0;

    vec('0,            3,  3,  330,  "zero_f0");
    vec(lo_ones(40),   5,  9,  590,  "f40_selA");
    vec('1,            2,  7,  275,  "ones_f55");
    vec(hi_ones(25),   17, 4,  415,  "f85_Bm1");
    vec(hi_ones(10),   6,  0,  3510, "wrap_f100");
    vec(lo_ones(20) & ~(55'd1 << 5), 20, 1, 129, "bubble_f19");
    vec(lo_ones(27),   10, 20, 2227, "f27_selB");
    vec(lo_ones(28),   10, 20, 1128, "f28_selA");
    vec(hi_ones(28),   10, 20, 1182, "f82_selA");
    vec(hi_ones(27),   10, 20, 2173, "f83_Bm1");
    vec(hi_ones(1),    0,  0,  3519, "max_f109");

    // Reset mid-stream with a non-zero snapshot on the bus.
    @(posedge clk40M); #2;
    bus.fine_raw_code = lo_ones(40);
    bus.counterA      = 5'd5;
    bus.counterB      = 5'd9;
    rst = 1'b1;
    @(posedge clk40M); #1;
    check("rst_mid", int'(bus.TDC_bin_code), 0);
    #1;
    rst = 1'b0;
    repeat (LAT) @(posedge clk40M);
    #1;
    check("rst_resume", int'(bus.TDC_bin_code), 590);

    // Mixed patterns with occasional reset; checked by the per-cycle compare.
    for (int i = 0; i < 80; i++) begin
      @(posedge clk40M); #2;
      case ($urandom_range(0, 2))
        0: bus.fine_raw_code = lo_ones($urandom_range(0, 55));
        1: bus.fine_raw_code = hi_ones($urandom_range(0, 55));
        default: bus.fine_raw_code = 55'({$urandom(), $urandom()});
      endcase
      bus.counterA = 5'($urandom_range(0, 31));
      bus.counterB = 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk40M); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk40M);
    @(negedge clk40M); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
